// File: rtl/register_bank_pkg.sv
// Shared constants and types for the register bank and the decode/write-back stages.
package register_bank_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int ZERO_REG       = 0;
   localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

   typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
   typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/register_bank_if.sv
// Read/write port bundle of the register bank; master drives indices and write-back, slave returns data.
interface register_bank_if
   import register_bank_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
);

   logic [ADDR_W-1:0] Read_Reg1;
   logic [ADDR_W-1:0] Read_Reg2;
   logic [ADDR_W-1:0] Write_Reg;
   logic [DATA_W-1:0] Write_Data;
   logic              RegWrite;
   logic [DATA_W-1:0] Read_Data1;
   logic [DATA_W-1:0] Read_Data2;
   logic [31:0]       Write_Count;

   modport master (
      output Read_Reg1, Read_Reg2, Write_Reg, Write_Data, RegWrite,
      input  Read_Data1, Read_Data2, Write_Count
   );

   modport slave (
      input  Read_Reg1, Read_Reg2, Write_Reg, Write_Data, RegWrite,
      output Read_Data1, Read_Data2, Write_Count
   );

endinterface

// File: rtl/register_bank_read_port.sv
// One combinational read port: zero-register masking, plus write-first bypass when
// REGFILE_BYPASS_EN is defined.
module register_bank_read_port
   import register_bank_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic [DATA_W-1:0] i_arr_data,
   input  logic [ADDR_W-1:0] i_rd_idx,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic [DATA_W-1:0] o_rd_data
);

   logic w_rd_zero;
   assign w_rd_zero = (i_rd_idx == ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
   logic w_hit;
   assign w_hit = i_rst_n && i_wr_en && (i_wr_idx != ADDR_W'(ZERO_REG)) && (i_wr_idx == i_rd_idx);

   always_comb begin
      o_rd_data = i_arr_data;
      if (w_rd_zero)  o_rd_data = '0;
      else if (w_hit) o_rd_data = i_wr_data;
   end
`else
   // Write-port inputs only matter for the bypass build.
   logic w_unused_wr;
   assign w_unused_wr = ^{i_rst_n, i_wr_en, i_wr_idx, i_wr_data};

   always_comb begin
      o_rd_data = i_arr_data;
      if (w_rd_zero) o_rd_data = '0;
   end
`endif

endmodule

// File: rtl/register_bank.sv
// 32x32 register file: two async read ports, one sync write port, reg 0 hardwired to zero,
// committed-write counter. Optional write-first bypass via REGFILE_BYPASS_EN.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic           Clock,
   input  logic           Reset_n,
   register_bank_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [31:0]       r_write_count;
   logic              w_commit;
   logic [DATA_W-1:0] w_arr_data1;
   logic [DATA_W-1:0] w_arr_data2;

   assign w_commit = bus.RegWrite && (bus.Write_Reg != ADDR_W'(ZERO_REG));

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_write_count <= '0;
      end else if (w_commit) begin
         r_regs[bus.Write_Reg] <= bus.Write_Data;
         r_write_count         <= r_write_count + 32'd1;
      end
   end

   assign w_arr_data1 = r_regs[bus.Read_Reg1];
   assign w_arr_data2 = r_regs[bus.Read_Reg2];

   register_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port1 (
      .i_arr_data (w_arr_data1),
      .i_rd_idx   (bus.Read_Reg1),
      .i_rst_n    (Reset_n),
      .i_wr_en    (bus.RegWrite),
      .i_wr_idx   (bus.Write_Reg),
      .i_wr_data  (bus.Write_Data),
      .o_rd_data  (bus.Read_Data1)
   );

   register_bank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_port2 (
      .i_arr_data (w_arr_data2),
      .i_rd_idx   (bus.Read_Reg2),
      .i_rst_n    (Reset_n),
      .i_wr_en    (bus.RegWrite),
      .i_wr_idx   (bus.Write_Reg),
      .i_wr_data  (bus.Write_Data),
      .o_rd_data  (bus.Read_Data2)
   );

   assign bus.Write_Count = r_write_count;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed cases plus random traffic against an array model.
module tb_register_bank;

   logic Clock;
   logic Reset_n;

   register_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   register_bank #(.DATA_W(32), .ADDR_W(5)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [31:0] m_mem [32];
   logic [31:0] m_cnt;
   int          n_pass;
   int          n_total;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_read(input int idx);
      logic [31:0] v;
      v = (idx == 0) ? 32'h0 : m_mem[idx];
`ifdef REGFILE_BYPASS_EN
      if (Reset_n && bus.RegWrite && bus.Write_Reg != 5'd0 && int'(bus.Write_Reg) == idx && idx != 0)
         v = bus.Write_Data;
`endif
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_cnt = 32'h0;
   endtask

   // Advance one clock edge, applying the write rule to the model, then settle.
   task automatic tick();
      @(posedge Clock);
      if (Reset_n && bus.RegWrite && bus.Write_Reg != 5'd0) begin
         m_mem[bus.Write_Reg] = bus.Write_Data;
         m_cnt = m_cnt + 32'd1;
      end
      #1;
   endtask

   task automatic set_read(input int a, input int b);
      bus.Read_Reg1 = 5'(a);
      bus.Read_Reg2 = 5'(b);
      #1;
   endtask

   task automatic check_reads(input string tag);
      check({tag, "_rd1"}, bus.Read_Data1, exp_read(int'(bus.Read_Reg1)));
      check({tag, "_rd2"}, bus.Read_Data2, exp_read(int'(bus.Read_Reg2)));
   endtask

   task automatic write_reg(input int idx, input logic [31:0] data);
      bus.RegWrite   = 1'b1;
      bus.Write_Reg  = 5'(idx);
      bus.Write_Data = data;
      tick();
      bus.RegWrite   = 1'b0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         set_read(i, 31 - i);
         check_reads(tag);
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      model_clear();
      Reset_n        = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.Write_Reg  = 5'd0;
      bus.Write_Data = 32'h0;
      bus.Read_Reg1  = 5'd0;
      bus.Read_Reg2  = 5'd0;

      // Reset state
      #2;
      for (int i = 0; i < 32; i++) begin
         set_read(i, 31 - i);
         check("rst_rd1", bus.Read_Data1, 32'h0);
         check("rst_rd2", bus.Read_Data2, 32'h0);
      end
      check("rst_count", bus.Write_Count, 32'h0);
      @(negedge Clock);
      Reset_n = 1'b1;
      #1;

      // Basic write
      write_reg(5, 32'hDEADBEEF);
      set_read(5, 5);
      check("w5_rd1", bus.Read_Data1, 32'hDEADBEEF);
      check("w5_rd2", bus.Read_Data2, 32'hDEADBEEF);
      check("w5_count", bus.Write_Count, 32'd1);

      // Write to register 0 is discarded and uncounted
      write_reg(0, 32'h12345678);
      set_read(0, 0);
      check("w0_rd1", bus.Read_Data1, 32'h0);
      check("w0_rd2", bus.Read_Data2, 32'h0);
      check("w0_count", bus.Write_Count, 32'd1);

      // Same-cycle read of the register being written
      write_reg(7, 32'h11);
      bus.RegWrite   = 1'b1;
      bus.Write_Reg  = 5'd7;
      bus.Write_Data = 32'h22;
      set_read(7, 7);
`ifdef REGFILE_BYPASS_EN
      check("rw7_pre_rd1", bus.Read_Data1, 32'h22);
      check("rw7_pre_rd2", bus.Read_Data2, 32'h22);
`else
      check("rw7_pre_rd1", bus.Read_Data1, 32'h11);
      check("rw7_pre_rd2", bus.Read_Data2, 32'h11);
`endif
      tick();
      bus.RegWrite = 1'b0;
      #1;
      check("rw7_post_rd1", bus.Read_Data1, 32'h22);
      check("rw7_post_rd2", bus.Read_Data2, 32'h22);
      check("rw7_count", bus.Write_Count, m_cnt);

      // Disabled writes leave state untouched
      for (int c = 0; c < 10; c++) begin
         bus.RegWrite   = 1'b0;
         bus.Write_Reg  = 5'($urandom_range(0, 31));
         bus.Write_Data = $urandom;
         set_read($urandom_range(0, 31), $urandom_range(0, 31));
         check_reads("nowr");
         tick();
         check("nowr_count", bus.Write_Count, m_cnt);
      end
      set_read(5, 7);
      check("nowr_r5", bus.Read_Data1, 32'hDEADBEEF);
      check("nowr_r7", bus.Read_Data2, 32'h22);

      // Random traffic
      for (int c = 0; c < 300; c++) begin
         bus.RegWrite   = ($urandom_range(0, 3) != 0);
         bus.Write_Reg  = 5'($urandom_range(0, 31));
         bus.Write_Data = $urandom;
         if ($urandom_range(0, 3) == 0) set_read(int'(bus.Write_Reg), $urandom_range(0, 31));
         else set_read($urandom_range(0, 31), $urandom_range(0, 31));
         check_reads("rnd_pre");
         tick();
         check_reads("rnd_post");
         check("rnd_count", bus.Write_Count, m_cnt);
      end
      bus.RegWrite = 1'b0;

      // Fill 1..31 with index*3, then assert reset mid-cycle with a write pending
      for (int i = 1; i < 32; i++) write_reg(i, 32'(i * 3));
      sweep("fill");
      check("fill_count", bus.Write_Count, m_cnt);
      bus.RegWrite   = 1'b1;
      bus.Write_Reg  = 5'd4;
      bus.Write_Data = 32'hAAAA_5555;
      set_read(4, 31);
      #2;
      Reset_n = 1'b0;
      model_clear();
      #1;
      check("midrst_count", bus.Write_Count, 32'h0);
      check("midrst_rd1", bus.Read_Data1, 32'h0);
      check("midrst_rd2", bus.Read_Data2, 32'h0);
      sweep("midrst");

      // Write presented on the edge that releases reset is not committed
      bus.RegWrite   = 1'b1;
      bus.Write_Reg  = 5'd9;
      bus.Write_Data = 32'hCAFEF00D;
      @(posedge Clock);
      Reset_n <= 1'b1;
      #1;
      bus.RegWrite = 1'b0;
      set_read(9, 9);
      check("rel_rd1", bus.Read_Data1, 32'h0);
      check("rel_rd2", bus.Read_Data2, 32'h0);
      check("rel_count", bus.Write_Count, 32'h0);

      write_reg(9, 32'h55);
      set_read(9, 0);
      check("post_rd1", bus.Read_Data1, 32'h55);
      check("post_rd2", bus.Read_Data2, 32'h0);
      check("post_count", bus.Write_Count, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
